// File: rtl/secuenciador_suma.sv
// secuenciador_suma: accumulates NTAPS signed operands through a shared external saturating adder.
// Optional sticky saturation flag enabled by defining SECUENCIADOR_SAT_EN.
module secuenciador_suma #(
  parameter int largo = 24,
  parameter int NTAPS = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [largo:0] in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [largo:0] suma_a,
  output logic [largo:0] suma_b,
  input  logic [largo:0] suma_y,
  output logic [largo:0] resultado,
  output logic           out_valid,
  input  logic           out_ack,
  output logic           busy,
  output logic           sat
);
  localparam int CW = $clog2(NTAPS);
  localparam logic [CW-1:0] last = CW'(NTAPS - 1);
  typedef enum logic [1:0] {IDLE, ACUM, DONE} state_t;
  state_t state, next;
  logic [largo:0] acc;
  logic [CW-1:0] cnt;
  logic beat, run;
  assign beat = state == ACUM && in_valid;
  assign run = start && (state == IDLE || (state == DONE && out_ack));
`ifdef SECUENCIADOR_SAT_EN
  logic sat_r, ovf;
  // the external adder clamps symmetrically, so either rail with like-signed operands means it clipped
  assign ovf = beat && suma_a[largo] == suma_b[largo] &&
               (suma_y == {1'b0, {largo{1'b1}}} || suma_y == {1'b1, {(largo-1){1'b0}}, 1'b1});
  always_ff @(posedge clk)
    if (reset || run) sat_r <= 1'b0;
    else if (ovf) sat_r <= 1'b1;
  assign sat = sat_r;
`else
  assign sat = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= next;
      if (run) begin
        acc <= '0;
        cnt <= '0;
      end else if (beat) begin
        acc <= suma_y;
        cnt <= cnt + 1'b1;
      end
    end
  end
  always_comb begin
    next = run ? ACUM :
           (beat && cnt == last) ? DONE :
           (state == DONE && out_ack) ? IDLE : state;
  end
  always_comb begin
    in_ready  = state == ACUM;
    out_valid = state == DONE;
    busy      = state != IDLE;
    suma_a    = in_ready ? acc : '0;
    suma_b    = in_ready ? in_data : '0;
    resultado = out_valid ? acc : '0;
  end
endmodule

// File: tb/tb_secuenciador_suma.sv
// tb_secuenciador_suma: directed and random checks of secuenciador_suma against a behavioural accumulator model.
module tb_secuenciador_suma;
  localparam int NT = 4;
  localparam longint MAXV = 2**24 - 1;
`ifdef SECUENCIADOR_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, in_valid = 1'b0, out_ack = 1'b0;
  logic signed [24:0] in_data = '0;
  logic signed [24:0] suma_a, suma_b, suma_y, resultado;
  logic in_ready, out_valid, busy, sat;
  int tests = 0, fails = 0;
  bit en = 1'b0;

  secuenciador_suma #(.largo(24), .NTAPS(NT)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .suma_a(suma_a), .suma_b(suma_b), .suma_y(suma_y),
    .resultado(resultado), .out_valid(out_valid), .out_ack(out_ack), .busy(busy), .sat(sat)
  );

  always #5 clk = ~clk;

  function automatic logic signed [24:0] sat_add(input logic signed [24:0] a, input logic signed [24:0] b);
    longint s;
    s = longint'(a) + longint'(b);
    return s > MAXV ? 25'(MAXV) : s < -MAXV ? 25'(-MAXV) : 25'(s);
  endfunction

  // external saturating adder the block shares
  assign suma_y = sat_add(suma_a, suma_b);

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // behavioural model: phase 0 idle, 1 collecting operands, 2 result waiting for ack
  int m_phase = 0, m_beats = 0;
  longint m_acc = 0;
  bit m_sat = 1'b0;
  always @(posedge clk) begin
    longint n;
    if (reset) begin
      m_phase = 0; m_acc = 0; m_beats = 0; m_sat = 1'b0;
    end else if ((m_phase == 0 || (m_phase == 2 && out_ack)) && start) begin
      m_phase = 1; m_acc = 0; m_beats = 0; m_sat = 1'b0;
    end else if (m_phase == 2 && out_ack) begin
      m_phase = 0;
    end else if (m_phase == 1 && in_valid) begin
      n = m_acc + longint'(in_data);
      n = n > MAXV ? MAXV : n < -MAXV ? -MAXV : n;
      if ((m_acc < 0) == (in_data < 0) && (n == MAXV || n == -MAXV)) m_sat = 1'b1;
      m_acc = n;
      m_beats++;
      if (m_beats == NT) m_phase = 2;
    end
  end

  always @(negedge clk) if (en) begin
    chk("in_ready", in_ready, m_phase == 1);
    chk("out_valid", out_valid, m_phase == 2);
    chk("busy", busy, m_phase != 0);
    chk("sat", sat, SAT_EN && m_sat);
    chk("suma_a", suma_a, m_phase == 1 ? m_acc : 64'd0);
    chk("suma_b", suma_b, m_phase == 1 ? longint'(in_data) : 64'd0);
    chk("resultado", resultado, m_phase == 2 ? m_acc : 64'd0);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic go;
    start = 1'b1; tick; start = 1'b0;
  endtask

  task automatic beat(input logic signed [24:0] d);
    in_valid = 1'b1; in_data = d; tick; in_valid = 1'b0; in_data = '0;
  endtask

  task automatic ack;
    out_ack = 1'b1; tick; out_ack = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    tick; tick;
    reset = 1'b0; en = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_resultado", resultado, 0);
    chk("rst_in_ready", in_ready, 0);
    // 1,2,3,4 back to back
    go;
    chk("s1_busy", busy, 1);
    for (int i = 1; i <= 4; i++) begin
      chk("s1_not_done_yet", out_valid, 0);
      beat(25'(i));
    end
    chk("s1_out_valid", out_valid, 1);
    chk("s1_resultado", resultado, 10);
    chk("s1_sat", sat, 0);
    ack;
    chk("s1_idle", busy, 0);
    // positive overflow clamps to the rail
    go;
    beat(25'h0C00000); beat(25'h0C00000); beat(25'd0); beat(25'd0);
    chk("s2_resultado", resultado, 64'h0FFFFFF);
    chk("s2_sat", sat, SAT_EN);
    ack;
    // gapped in_valid
    go;
    for (int i = 0; i < 7; i++) begin
      in_valid = (7'b1011001 >> i) & 1'b1;
      in_data = 25'd5;
      tick;
    end
    in_valid = 1'b0;
    chk("s3_out_valid", out_valid, 1);
    chk("s3_resultado", resultado, 20);
    ack;
    // reset mid-run wins over everything else
    go;
    beat(25'd7); beat(25'd9);
    reset = 1'b1; start = 1'b1; in_valid = 1'b1; out_ack = 1'b1; tick;
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; out_ack = 1'b0;
    chk("s4_busy", busy, 0);
    chk("s4_in_ready", in_ready, 0);
    chk("s4_out_valid", out_valid, 0);
    chk("s4_resultado", resultado, 0);
    chk("s4_sat", sat, 0);
    chk("s4_suma_a", suma_a, 0);
    go;
    for (int i = 0; i < 4; i++) beat(25'd1);
    chk("s4_resultado2", resultado, 4);
    ack;
    // ack withheld while start pulses, then ack+start chains a new run
    go;
    for (int i = 0; i < 4; i++) beat(25'd3);
    for (int i = 0; i < 5; i++) begin
      start = i[0]; tick;
      chk("s5_hold_valid", out_valid, 1);
      chk("s5_hold_res", resultado, 12);
    end
    out_ack = 1'b1; start = 1'b1; tick;
    out_ack = 1'b0; start = 1'b0;
    chk("s5_chain_busy", busy, 1);
    chk("s5_chain_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) beat(-25'sd2);
    chk("s5_chain_res", resultado, -64'sd8);
    ack;
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom;
      reset = ($urandom_range(0, 63) == 0);
      start = ($urandom_range(0, 3) == 0);
      in_valid = r[2];
      out_ack = ($urandom_range(0, 2) == 0);
      in_data = r[1:0] == 2'd0 ? r[31:7] : 25'(int'(r[15:8]) - 128);
      tick;
    end
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ack = 1'b0;
    tick; tick;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/secuenciador_suma.md
SECUENCIADOR_SUMA -- requirements
Module: secuenciador_suma

Interface
REQ-001 SHALL have parameter largo, default 24; data words are signed, largo+1 bits wide.
REQ-002 SHALL have parameter NTAPS, default 4; operands accumulated per run, range 2..255.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port start, input, 1; requests a new accumulation run.
REQ-006 SHALL have port in_data, input, largo+1; signed operand.
REQ-007 SHALL have port in_valid, input, 1; in_data is valid this cycle.
REQ-008 SHALL have port in_ready, output, 1; block accepts an operand this cycle.
REQ-009 SHALL have ports suma_a and suma_b, each output, largo+1; operands driven to the shared external saturating adder.
REQ-010 SHALL have port suma_y, input, largo+1; saturated sum returned combinationally by that adder.
REQ-011 SHALL have port resultado, output, largo+1; final accumulated value.
REQ-012 SHALL have port out_valid, output, 1; resultado is valid.
REQ-013 SHALL have port out_ack, input, 1; consumer accepts resultado.
REQ-014 SHALL have port busy, output, 1; high in any state other than IDLE.
REQ-015 SHALL have port sat, output, 1; sticky saturation flag for the current run.

Function
REQ-016 SHALL implement FSM states IDLE, ACUM and DONE, with a registered accumulator acc (largo+1) and a beat counter cnt.
REQ-017 IDLE: in_ready=0 and out_valid=0; start=1 -> ACUM, acc<=0, cnt<=0, sat<=0.
REQ-018 ACUM: in_ready=1; suma_a=acc and suma_b=in_data, combinationally.
REQ-019 ACUM: a beat is accepted only when in_valid=1 and in_ready=1; on that edge acc<=suma_y and cnt<=cnt+1; without a beat, acc and cnt hold.
REQ-020 ACUM: the beat accepted with cnt==NTAPS-1 -> DONE; out_valid rises on the next cycle.
REQ-021 DONE: out_valid=1, in_ready=0, resultado=acc held stable until out_ack=1.
REQ-022 DONE with out_ack=1 and start=0 -> IDLE.
REQ-023 DONE with out_ack=1 and start=1 -> ACUM directly, clearing acc, cnt and sat as in REQ-017.
REQ-024 start SHALL be ignored in ACUM, and in DONE unless out_ack=1.
REQ-025 Outside ACUM, suma_a and suma_b SHALL be 0.
REQ-026 The block SHALL never modify suma_y; all saturation arithmetic stays in the external adder.
REQ-027 Minimum run latency: NTAPS accepted beats, plus 1 cycle to out_valid.

Reset
REQ-028 reset=1 at a clock edge SHALL force IDLE, acc=0, cnt=0, sat=0, resultado=0, out_valid=0, in_ready=0 and busy=0, from any state, including mid-run.
REQ-029 reset SHALL take priority over start, in_valid and out_ack in the same cycle.

Configuration
REQ-030 With macro SECUENCIADOR_SAT_EN defined, sat SHALL set on any accepted beat where suma_a[largo]==suma_b[largo] and suma_y equals {0,all ones} or {1,zeros,1}; it then stays set until the next run start or reset.
REQ-031 Without SECUENCIADOR_SAT_EN, sat SHALL be tied to 0 and the detection logic SHALL be absent.

Verification (largo=24, NTAPS=4)
REQ-032 Bench SHALL check: start, then operands 1,2,3,4 back-to-back -> out_valid on the cycle after beat 4, resultado=10, sat=0.
REQ-033 Bench SHALL check: operands 0x0C00000,0x0C00000,0,0 with SECUENCIADOR_SAT_EN defined -> resultado=0x0FFFFFF, sat=1; with the macro undefined -> sat=0.
REQ-034 Bench SHALL check: in_valid toggling 1,0,0,1,1,0,1 with data 5 -> exactly 4 beats counted, resultado=20.
REQ-035 Bench SHALL check: reset asserted after 2 accepted beats -> next cycle is IDLE with all outputs 0; a following run of 1,1,1,1 gives resultado=4.
REQ-036 Bench SHALL check: out_ack withheld 5 cycles while start pulses -> resultado stable and start ignored; out_ack=1 with start=1 -> ACUM next cycle, busy stays 1.
